// File: rtl/tron_trail_compositor.sv
// Trail frame buffer with a 2-cycle video read pipeline and a once-per-frame
// probe/mark FSM that detects bike collisions and stamps each bike's colour.
`timescale 1ns/1ps
module tron_trail_compositor #(
    parameter int NUM_PLAYERS  = 2,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PIX_BITS     = 4,
    parameter int PIX_PER_WORD = 2,
    parameter int BIKE_LEN     = 16,
    parameter int BIKE_HALF    = 3,
    parameter int BG_IDX       = 0,
    parameter int ADDR_W       = $clog2(H_RES*V_RES/PIX_PER_WORD),
    parameter int WORD_W       = PIX_BITS*PIX_PER_WORD
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [PIX_BITS-1:0]       Bike_In,
    input  logic [10*NUM_PLAYERS-1:0] Head_X,
    input  logic [10*NUM_PLAYERS-1:0] Head_Y,
    input  logic [2*NUM_PLAYERS-1:0]  Dir,
    input  logic [NUM_PLAYERS-1:0]    Alive,
    input  logic                      Hit_Clr,
    input  logic                      Ext_WE,
    input  logic [ADDR_W-1:0]         Ext_Addr,
    input  logic [WORD_W-1:0]         Ext_Data,
    output logic [PIX_BITS-1:0]       color_enum,
    output logic [NUM_PLAYERS-1:0]    Hit,
    output logic                      Busy,
    output logic                      Pass_Done
);

    localparam int DEPTH = H_RES*V_RES/PIX_PER_WORD;
    localparam int WPL   = H_RES/PIX_PER_WORD;
    localparam int SEL_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int P_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);
    localparam logic [9:0] LEN   = 10'(BIKE_LEN);
    localparam logic [9:0] HALF  = 10'(BIKE_HALF);
    localparam logic [9:0] PPW   = 10'(PIX_PER_WORD);
    localparam logic [PIX_BITS-1:0] BG          = PIX_BITS'(BG_IDX);
    localparam logic [PIX_BITS-1:0] TRANSPARENT = '1;
    localparam logic [P_W-1:0]      LAST        = P_W'(NUM_PLAYERS-1);

    typedef enum logic [2:0] {
        IDLE, PROBE_RD, PROBE_CHK, MARK_RD, MARK_WR, NEXT, DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] wordAddr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(y) * ADDR_W'(WPL) + ADDR_W'(x / PPW);
    endfunction

    function automatic logic [SEL_W-1:0] pixSel(input logic [9:0] x);
        return SEL_W'(x % PPW);
    endfunction

    function automatic logic [PIX_BITS-1:0] fieldOf(input logic [WORD_W-1:0] w, input logic [SEL_W-1:0] s);
        return w[s*PIX_BITS +: PIX_BITS];
    endfunction

    logic [WORD_W-1:0]      mem [DEPTH];
    logic [WORD_W-1:0]      rdA_q, rdB_q;
    logic [ADDR_W-1:0]      addrB;
    logic                   weB, reB;
    logic [WORD_W-1:0]      wdataB;

    logic [SEL_W-1:0]       vidSel_q;
    logic [PIX_BITS-1:0]    bike_q, color_q;

    state_t                 state_q;
    logic [P_W-1:0]         playerIdx_q;
    logic [NUM_PLAYERS-1:0] hit_q, hitSet;
    logic                   busy_q, done_q;
    logic [SEL_W-1:0]       probeSel_q;
    logic                   sync1_q, sync2_q, sync3_q;
    logic                   frameRise;

    logic [9:0]             headX, headY, probeX, probeY;
    logic [1:0]             dirP;
    logic                   probeOob, headOob, playerActive;
    logic [PIX_BITS-1:0]    markColour;

    // Frame buffer: port A feeds video, port B is shared between FSM and external writer.
    always_ff @(posedge Clk) begin
        rdA_q <= mem[wordAddr(DrawX, DrawY)];
        if (weB) mem[addrB] <= wdataB;
        if (reB) rdB_q <= mem[addrB];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vidSel_q <= '0;
            bike_q   <= '0;
            color_q  <= '0;
        end else begin
            vidSel_q <= pixSel(DrawX);
            bike_q   <= Bike_In;
            color_q  <= (bike_q != TRANSPARENT) ? bike_q : fieldOf(rdA_q, vidSel_q);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign frameRise = sync2_q & ~sync3_q;

    // Look-ahead point in 10-bit wrapping arithmetic; underflow lands above the screen limits.
    always_comb begin
        headX  = Head_X[10*playerIdx_q +: 10];
        headY  = Head_Y[10*playerIdx_q +: 10];
        dirP   = Dir[2*playerIdx_q +: 2];
        probeX = headX;
        probeY = headY;
        case (dirP)
            2'b00:   begin probeX = headX + HALF; probeY = headY - LEN;  end
            2'b01:   begin probeX = headX + HALF; probeY = headY + LEN;  end
            2'b10:   begin probeX = headX - LEN;  probeY = headY + HALF; end
            default: begin probeX = headX + LEN;  probeY = headY + HALF; end
        endcase
    end

    assign probeOob     = (probeX >= H_LIM) || (probeY >= V_LIM);
    assign headOob      = (headX >= H_LIM) || (headY >= V_LIM);
    assign playerActive = Alive[playerIdx_q] && !hit_q[playerIdx_q];
    assign markColour   = PIX_BITS'(playerIdx_q) + PIX_BITS'(1);

    always_comb begin
        hitSet = '0;
        if (state_q == PROBE_RD && playerActive && probeOob) hitSet[playerIdx_q] = 1'b1;
        if (state_q == PROBE_CHK && fieldOf(rdB_q, probeSel_q) != BG) hitSet[playerIdx_q] = 1'b1;
    end

    always_comb begin
        addrB  = Ext_Addr;
        weB    = Ext_WE && !busy_q;
        reB    = 1'b0;
        wdataB = Ext_Data;
        if (busy_q) begin
            addrB  = (state_q == PROBE_RD) ? wordAddr(probeX, probeY) : wordAddr(headX, headY);
            weB    = (state_q == MARK_WR) && !headOob;
            reB    = (state_q == PROBE_RD && playerActive && !probeOob) || (state_q == MARK_RD);
            wdataB = rdB_q;
            wdataB[pixSel(headX)*PIX_BITS +: PIX_BITS] = markColour;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            playerIdx_q <= '0;
            hit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            probeSel_q  <= '0;
        end else begin
            hit_q  <= (Hit_Clr ? '0 : hit_q) | hitSet;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frameRise) begin
                        playerIdx_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= PROBE_RD;
                    end
                end
                PROBE_RD: begin
                    if (!playerActive || probeOob) begin
                        state_q <= NEXT;
                    end else begin
                        probeSel_q <= pixSel(probeX);
                        state_q    <= PROBE_CHK;
                    end
                end
                PROBE_CHK: state_q <= MARK_RD;
                MARK_RD:   state_q <= MARK_WR;
                MARK_WR:   state_q <= NEXT;
                NEXT: begin
                    if (playerIdx_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        playerIdx_q <= playerIdx_q + 1'b1;
                        state_q     <= PROBE_RD;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign color_enum = color_q;
    assign Hit        = hit_q;
    assign Busy       = busy_q;
    assign Pass_Done  = done_q;

endmodule
